// File: rtl/rsc_encoder_pair.sv
// Paired 8-state RSC constituent encoders (g0=1+D^2+D^3, g1=1+D+D^3) for the NB-IoT turbo encoder.
// After K accepted bits both shift registers freeze and are presented with done=2'b11 for trellis termination.
module rsc_encoder_pair #(
   parameter int KW   = 13,
   parameter int KMIN = 40,
   parameter int KMAX = 6144
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [KW-1:0] blk_len,
   input  logic          in_valid,
   input  logic          c_in,
   input  logic          ci_in,
   output logic          out_valid,
   output logic          x,
   output logic          z,
   output logic          zi,
   output logic          busy,
   output logic          err,
   output logic [0:1]    done,
   output logic [1:3]    n,
   output logic [1:3]    m
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        r_state, w_nextState;
   logic [KW-1:0] r_blkLen, r_count;
   logic [1:3]    r_n, r_m;
   logic [0:1]    r_done;
   logic          r_outValid, r_x, r_z, r_zi, r_err;

   logic w_legal, w_accept, w_last;
   logic w_a1, w_z1, w_a2, w_z2;

   // A start in the same cycle as a data bit takes priority, so that bit is never accepted.
   assign w_legal  = (blk_len >= KW'(KMIN)) && (blk_len <= KW'(KMAX));
   assign w_accept = (r_state == RUN) && in_valid && !start;
   assign w_last   = w_accept && (r_count == (r_blkLen - KW'(1)));

   assign w_a1 = c_in ^ r_n[2] ^ r_n[3];
   assign w_z1 = w_a1 ^ r_n[1] ^ r_n[3];
   assign w_a2 = ci_in ^ r_m[2] ^ r_m[3];
   assign w_z2 = w_a2 ^ r_m[1] ^ r_m[3];

   always_comb begin
      w_nextState = r_state;
      if (start) begin
         w_nextState = w_legal ? RUN : IDLE;
      end else if (w_last) begin
         w_nextState = DONE;
      end
   end

   // State registers are only touched by start or an accepted bit; otherwise the encoders hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_blkLen   <= '0;
         r_count    <= '0;
         r_n        <= 3'b000;
         r_m        <= 3'b000;
         r_done     <= 2'b00;
         r_outValid <= 1'b0;
         r_x        <= 1'b0;
         r_z        <= 1'b0;
         r_zi       <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_outValid <= w_accept;
         if (start) begin
            r_n     <= 3'b000;
            r_m     <= 3'b000;
            r_done  <= 2'b00;
            r_count <= '0;
            r_err   <= !w_legal;
            if (w_legal) begin
               r_blkLen <= blk_len;
            end
         end else if (w_accept) begin
            r_n     <= {w_a1, r_n[1], r_n[2]};
            r_m     <= {w_a2, r_m[1], r_m[2]};
            r_x     <= c_in;
            r_z     <= w_z1;
            r_zi    <= w_z2;
            r_count <= r_count + KW'(1);
            if (w_last) begin
               r_done <= 2'b11;
            end
         end
      end
   end

   assign out_valid = r_outValid;
   assign x         = r_x;
   assign z         = r_z;
   assign zi        = r_zi;
   assign busy      = (r_state == RUN);
   assign err       = r_err;
   assign done      = r_done;
   assign n         = r_n;
   assign m         = r_m;

endmodule

// File: tb/tb_rsc_encoder_pair.sv
// Directed bench for rsc_encoder_pair: a behavioural model pushes expected x/z/zi into a scoreboard
// queue as bits are driven; entries are popped and compared whenever the DUT raises out_valid.
module tb_rsc_encoder_pair;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [12:0] blk_len;
   logic        in_valid;
   logic        c_in;
   logic        ci_in;
   logic        out_valid, x, z, zi, busy, err;
   logic [0:1]  done;
   logic [1:3]  n, m;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state: 0=IDLE 1=RUN 2=DONE
   int         mState;
   logic [1:3] mN, mM;
   int         mCnt, mK;
   logic       mErr;
   logic [0:1] mDone;
   logic [2:0] expQ[$];

   rsc_encoder_pair #(.KW(13), .KMIN(40), .KMAX(6144)) dut (
      .clk(clk), .rst(rst), .start(start), .blk_len(blk_len),
      .in_valid(in_valid), .c_in(c_in), .ci_in(ci_in),
      .out_valid(out_valid), .x(x), .z(z), .zi(zi),
      .busy(busy), .err(err), .done(done), .n(n), .m(m)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Per-cycle comparison of control outputs and scoreboard pop for data.
   task automatic checkOutput(input logic expValid);
      logic [2:0] e;
      check("out_valid", out_valid, expValid);
      check("busy", busy, (mState == 1));
      check("done", done, mDone);
      check("err", err, mErr);
      if (out_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
         end else begin
            e = expQ.pop_front();
            check("xzzi", {x, z, zi}, e);
         end
      end
   endtask

   task automatic applyStimulus(input logic st, input int k, input logic iv, input logic c, input logic ci);
      logic a1, a2, z1, z2, expValid;
      start    = st;
      blk_len  = k[12:0];
      in_valid = iv;
      c_in     = c;
      ci_in    = ci;
      expValid = 1'b0;
      if (st) begin
         if (k >= 40 && k <= 6144) begin
            mState = 1; mN = 3'b000; mM = 3'b000; mCnt = 0; mK = k; mErr = 1'b0; mDone = 2'b00;
         end else begin
            mState = 0; mErr = 1'b1; mDone = 2'b00;
         end
      end else if (mState == 1 && iv) begin
         a1 = c ^ mN[2] ^ mN[3];
         z1 = a1 ^ mN[1] ^ mN[3];
         a2 = ci ^ mM[2] ^ mM[3];
         z2 = a2 ^ mM[1] ^ mM[3];
         expQ.push_back({c, z1, z2});
         mN = {a1, mN[1], mN[2]};
         mM = {a2, mM[1], mM[2]};
         mCnt++;
         expValid = 1'b1;
         if (mCnt == mK) begin
            mState = 2;
            mDone  = 2'b11;
         end
      end
      @(posedge clk);
      #1;
      start    = 1'b0;
      in_valid = 1'b0;
      checkOutput(expValid);
   endtask

   task automatic applyReset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mState = 0; mN = 3'b000; mM = 3'b000; mCnt = 0; mK = 0; mErr = 1'b0; mDone = 2'b00;
      expQ.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_xzzi", {x, z, zi}, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_done", done, 0);
      check("rst_n", n, 0);
      check("rst_m", m, 0);
   endtask

   task automatic randomBits(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         applyStimulus(1'b0, $urandom_range(8191), 1'b1, 1'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; blk_len = '0; in_valid = 1'b0; c_in = 1'b0; ci_in = 1'b0;
      applyReset();

      $display("[TB] all-zero block K=40");
      applyStimulus(1'b1, 40, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
      check("zero_n", n, 3'b000);
      check("zero_m", m, 3'b000);
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);

      $display("[TB] impulse response c=1,0,0");
      applyStimulus(1'b1, 40, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 40, 1'b1, 1'b1, 1'b0);
      check("imp_z1", z, 1);
      applyStimulus(1'b0, 40, 1'b1, 1'b0, 1'b0);
      check("imp_z2", z, 1);
      applyStimulus(1'b0, 40, 1'b1, 1'b0, 1'b0);
      check("imp_z3", z, 1);
      check("imp_n", n, 3'b101);
      check("imp_m", m, 3'b000);
      randomBits(37);
      check("imp_final_n", n, mN);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b1, 1'($urandom), 1'($urandom));
      check("frozen_n", n, mN);
      check("frozen_m", m, mM);

      $display("[TB] gapped input K=40");
      applyStimulus(1'b1, 40, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 82; i++) applyStimulus(1'b0, 0, (i % 2) == 0, 1'($urandom), 1'($urandom));

      $display("[TB] illegal block lengths then K=6144");
      applyStimulus(1'b1, 39, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 6145, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 6144, 1'b0, 1'b0, 1'b0);
      randomBits(6144);
      check("k6144_n", n, mN);
      check("k6144_m", m, mM);
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);

      $display("[TB] abort K=100 after 50 bits");
      applyStimulus(1'b1, 100, 1'b0, 1'b0, 1'b0);
      randomBits(50);
      applyStimulus(1'b1, 40, 1'b1, 1'b1, 1'b1);
      check("abort_n", n, 3'b000);
      check("abort_m", m, 3'b000);
      randomBits(40);

      $display("[TB] start coincident with K-th bit");
      applyStimulus(1'b1, 40, 1'b0, 1'b0, 1'b0);
      randomBits(39);
      applyStimulus(1'b1, 40, 1'b1, 1'b1, 1'b0);
      randomBits(40);

      $display("[TB] reset mid-block");
      applyStimulus(1'b1, 40, 1'b0, 1'b0, 1'b0);
      randomBits(20);
      applyReset();
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b1);

      check("scoreboard_empty", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rsc_encoder_pair.md
Name: rsc_encoder_pair

Overview:
- Constituent-encoder stage of the NB-IoT uplink turbo encoder, directly upstream of trellis termination.
- Runs the two 8-state RSC encoders (transfer function [1, g1/g0], g0=1+D^2+D^3, g1=1+D+D^3) in lockstep:
  - encoder 1 on the code block bits c;
  - encoder 2 on the interleaved bits c'.
- Emits systematic x and parities z, z' per bit.
- After K bits, freezes both shift registers and presents them with done=2'b11 for the termination stage.

Parameters:
- KW, 13, width of block-length input (K up to 6144)
- KMIN, 40, smallest legal block length
- KMAX, 6144, largest legal block length

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; latches blk_len, clears encoders, begins block
- blk_len  input  KW  block length K, sampled on start
- in_valid  input  1  c_in/ci_in valid this cycle
- c_in  input  1  code block bit c_k
- ci_in  input  1  interleaved bit c'_k (same index k)
- out_valid  output  1  x/z/zi valid
- x  output  1  systematic bit x_k (= c_k)
- z  output  1  encoder-1 parity z_k
- zi  output  1  encoder-2 parity z'_k
- busy  output  1  high in RUN
- err  output  1  sticky: start with illegal K; cleared by next legal start
- done  output  [0:1]  done[0]=encoder 1 finished, done[1]=encoder 2 finished
- n  output  [1:3]  encoder-1 register, n[1]=D stage, n[3]=D^3 stage
- m  output  [1:3]  encoder-2 register, same ordering

Behaviour:
- Reset (rst=1 at clock edge): state IDLE, n=m=3'b000, done=2'b00, out_valid=0, x=z=zi=0, busy=0, err=0, bit counter=0. Reset wins over every other input, including mid-block; a block in progress is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start & legal K--> RUN.
  - RUN --K-th accepted bit--> DONE.
  - DONE --start & legal K--> RUN.
  - Any state --start & illegal K (K<KMIN or K>KMAX)--> IDLE with err=1 and done=00.
- On legal start, in the cycle after: n=m=000, done=00, counter=0, K latched, err=0, busy=1.
- Start while in RUN aborts the current block and restarts cleanly. No outputs from the aborted block appear after the start cycle.
- RUN, per accepted bit (in_valid=1):
  - Encoder 1 feedback: a=c_in^n[2]^n[3].
  - Encoder 1 parity: z=a^n[1]^n[3].
  - Encoder 1 update: n[3]<=n[2], n[2]<=n[1], n[1]<=a.
  - Encoder 2: identical form with ci_in and m, producing zi.
  - x<=c_in; out_valid<=1; counter increments.
- Latency: exactly 1 cycle from accepted bit to out_valid. in_valid gaps allowed; out_valid=0 in the cycle following an idle input cycle.
- in_valid outside RUN: ignored; no output, registers unchanged.
- Block end: the cycle after the K-th accepted bit:
  - done=2'b11, busy=0, state DONE;
  - n, m hold the final states and stay frozen until the next start or rst.
- done bits always rise together. Both encoders consume paired bits, so 2'b01 and 2'b10 never occur.
- Counter compares against the latched K. A K change on blk_len without start has no effect.
- start in the same cycle as the K-th bit: start wins; the K-th bit is dropped and done never rises for that block.

Test Plan:
- rst, start with K=40, 40 bits c=ci=0 -> 40 out_valid pulses with z=zi=0; next cycle done=2'b11, n=m=000, busy=0.
- start K=40, first bits c=1,0,0 (ci=0) -> z=1,1,1 on successive outputs; n after bit 3 = {n[1],n[2],n[3]}={1,0,1}; zi=0, m=000.
- start K=40 with in_valid toggling every other cycle -> exactly 40 out_valid pulses, each 1 cycle after its input; done rises only after the 40th.
- start K=39, then separately K=6145 -> err=1, state IDLE, done=00. Then start K=6144 -> err=0 and 6144 outputs, then done=11.
- Abort: start K=100, send 50 bits, pulse start K=40 -> encoders reset to 000, counter restarts, done=11 only after 40 further bits. Separately, rst after 20 bits -> all outputs at reset values next cycle.
- Random c, c' for K=6144 vs reference model -> bit-exact x/z/zi stream and final n, m. Those n, m fed to trellis termination yield 12 tail bits driving both encoder states to 000.
